id_stage: RTL and testbench

Instruction-decode stage of the 5-stage pipeline. Decodes the IF/ID instruction word, reads operands from a 64×32 register file written by the write-back stage, and computes the branch target pc + y. It detects load-use hazards against the instruction currently in EX, and produces every `*_id` control and data signal consumed by the ID/EX pipeline buffer.

---
 rtl/scu_pkg.sv | 57 +++++
 rtl/id_stage_if.sv | 45 ++++
 rtl/reg_file.sv | 35 +++
 rtl/id_stage.sv | 120 ++++++++++++
 tb/tb_id_stage.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/scu_pkg.sv
// Shared decode constants for the pipeline: opcodes, ALU and write-back encodings,
// instruction field positions and the decoded control bundle.
package scu_pkg;

   localparam int unsigned Xlen    = 32;
   localparam int unsigned RegIdxW = 6;

   localparam int unsigned OpcMsb = 31;
   localparam int unsigned OpcLsb = 28;
   localparam int unsigned RdMsb  = 27;
   localparam int unsigned RdLsb  = 22;
   localparam int unsigned RsMsb  = 21;
   localparam int unsigned RsLsb  = 16;
   localparam int unsigned RtMsb  = 15;
   localparam int unsigned RtLsb  = 10;
   localparam int unsigned ImmMsb = 15;

   localparam logic [3:0] OpNop  = 4'b0000;
   localparam logic [3:0] OpSt   = 4'b0011;
   localparam logic [3:0] OpAdd  = 4'b0100;
   localparam logic [3:0] OpInc  = 4'b0101;
   localparam logic [3:0] OpNeg  = 4'b0110;
   localparam logic [3:0] OpSub  = 4'b0111;
   localparam logic [3:0] OpJ    = 4'b1000;
   localparam logic [3:0] OpBrz  = 4'b1001;
   localparam logic [3:0] OpJm   = 4'b1010;
   localparam logic [3:0] OpBrn  = 4'b1011;
   localparam logic [3:0] OpLd   = 4'b1110;
   localparam logic [3:0] OpSvpc = 4'b1111;

   localparam logic [2:0] AluPass = 3'b000;
   localparam logic [2:0] AluAdd  = 3'b001;
   localparam logic [2:0] AluNeg  = 3'b011;
   localparam logic [2:0] AluSub  = 3'b100;

   localparam logic [1:0] WbAlu = 2'b00;
   localparam logic [1:0] WbMem = 2'b01;
   localparam logic [1:0] WbPcy = 2'b10;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_wrt;
      logic       branch_zero;
      logic       branch_neg;
      logic       jump;
      logic       jump_mem;
      logic [1:0] wb_ctrl;
   } ctrl_t;

   function automatic logic [Xlen-1:0] sext16(logic [15:0] v);
      return {{(Xlen - 16){v[15]}}, v};
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID, EX feedback, write-back and ID/EX signals of the decode stage.
interface id_stage_if;
   import scu_pkg::*;

   logic [Xlen-1:0]    instr_id;
   logic [Xlen-1:0]    pc_id;
   logic               flush;
   logic               memRead_ex;
   logic [RegIdxW-1:0] rd_ex;
   logic               wb_regWrt;
   logic [RegIdxW-1:0] wb_rd;
   logic [Xlen-1:0]    wb_data;

   logic               stall;
   logic [2:0]         aluOp_id;
   logic               memRead_id;
   logic               memWrite_id;
   logic               aluSrc_id;
   logic               regWrt_id;
   logic               branchZero_id;
   logic               branchNeg_id;
   logic               jump_id;
   logic               jumpMem_id;
   logic [1:0]         writeBackControl_id;
   logic [Xlen-1:0]    xrs_id;
   logic [Xlen-1:0]    xrt_id;
   logic [Xlen-1:0]    y_id;
   logic [Xlen-1:0]    pc_plus_y_id;
   logic [RegIdxW-1:0] rd_id;

   modport master (
      output instr_id, pc_id, flush, memRead_ex, rd_ex, wb_regWrt, wb_rd, wb_data,
      input  stall, aluOp_id, memRead_id, memWrite_id, aluSrc_id, regWrt_id, branchZero_id,
             branchNeg_id, jump_id, jumpMem_id, writeBackControl_id, xrs_id, xrt_id, y_id,
             pc_plus_y_id, rd_id
   );

   modport slave (
      input  instr_id, pc_id, flush, memRead_ex, rd_ex, wb_regWrt, wb_rd, wb_data,
      output stall, aluOp_id, memRead_id, memWrite_id, aluSrc_id, regWrt_id, branchZero_id,
             branchNeg_id, jump_id, jumpMem_id, writeBackControl_id, xrs_id, xrt_id, y_id,
             pc_plus_y_id, rd_id
   );

endinterface

// File: rtl/reg_file.sv
// Register file: two combinational read ports with write bypass, one write port,
// asynchronous clear of every entry.
module reg_file
   import scu_pkg::*;
#(
   parameter int unsigned Regs  = 64,
   parameter int unsigned Width = Xlen,
   localparam int unsigned AddrW = $clog2(Regs)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             we,
   input  logic [AddrW-1:0] waddr,
   input  logic [Width-1:0] wdata,
   input  logic [AddrW-1:0] raddr_a,
   input  logic [AddrW-1:0] raddr_b,
   output logic [Width-1:0] rdata_a,
   output logic [Width-1:0] rdata_b
);

   logic [Width-1:0] mem_q [Regs];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q <= '{default: '0};
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Same-cycle bypass lets decode see the value being written back this cycle.
   assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
   assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: opcode decode, operand read, branch target, and
// load-use hazard detection with bubble insertion.
module id_stage
   import scu_pkg::*;
#(
   parameter int unsigned REGS = 64,
   parameter int unsigned XLEN = 32
) (
   input logic     clock,
   input logic     reset_n,
   id_stage_if.slave bus
);

   logic [3:0]         opcode;
   logic [RegIdxW-1:0] rs;
   logic [RegIdxW-1:0] rt;
   logic [Xlen-1:0]    y;
   ctrl_t              ctrl;
   ctrl_t              ctrl_out;
   logic               rs_used;
   logic               rt_used;
   logic               hazard;
   logic               bubble;

   assign opcode = bus.instr_id[OpcMsb:OpcLsb];
   assign rs     = bus.instr_id[RsMsb:RsLsb];
   assign rt     = bus.instr_id[RtMsb:RtLsb];
   assign y      = sext16(bus.instr_id[ImmMsb:0]);

   always_comb begin
      ctrl         = '0;
      ctrl.alu_op  = AluPass;
      ctrl.wb_ctrl = WbAlu;
      rs_used      = 1'b1;
      rt_used      = 1'b0;
      unique case (opcode)
         OpSvpc: begin
            ctrl.wb_ctrl = WbPcy;
            ctrl.reg_wrt = 1'b1;
            rs_used      = 1'b0;
         end
         OpLd: begin
            ctrl.mem_read = 1'b1;
            ctrl.wb_ctrl  = WbMem;
            ctrl.reg_wrt  = 1'b1;
         end
         OpSt: begin
            ctrl.mem_write = 1'b1;
            rt_used        = 1'b1;
         end
         OpAdd: begin
            ctrl.alu_op  = AluAdd;
            ctrl.reg_wrt = 1'b1;
            rt_used      = 1'b1;
         end
         OpInc: begin
            ctrl.alu_op  = AluAdd;
            ctrl.alu_src = 1'b1;
            ctrl.reg_wrt = 1'b1;
         end
         OpNeg: begin
            ctrl.alu_op  = AluNeg;
            ctrl.reg_wrt = 1'b1;
         end
         OpSub: begin
            ctrl.alu_op  = AluSub;
            ctrl.reg_wrt = 1'b1;
            rt_used      = 1'b1;
         end
         OpJ:   ctrl.jump        = 1'b1;
         OpBrz: ctrl.branch_zero = 1'b1;
         OpJm: begin
            ctrl.jump_mem = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         OpBrn: ctrl.branch_neg = 1'b1;
         OpNop: rs_used = 1'b0;
         default: rs_used = 1'b0;
      endcase
   end

   assign hazard = bus.memRead_ex &
                   (((bus.rd_ex == rs) & rs_used) | ((bus.rd_ex == rt) & rt_used));

   // A flush redirects fetch, so it overrides the stall while still forcing a bubble.
   assign bus.stall = reset_n & hazard & ~bus.flush;
   assign bubble    = ~reset_n | hazard | bus.flush;
   assign ctrl_out  = bubble ? '0 : ctrl;

   assign bus.aluOp_id           = ctrl_out.alu_op;
   assign bus.memRead_id         = ctrl_out.mem_read;
   assign bus.memWrite_id        = ctrl_out.mem_write;
   assign bus.aluSrc_id          = ctrl_out.alu_src;
   assign bus.regWrt_id          = ctrl_out.reg_wrt;
   assign bus.branchZero_id      = ctrl_out.branch_zero;
   assign bus.branchNeg_id       = ctrl_out.branch_neg;
   assign bus.jump_id            = ctrl_out.jump;
   assign bus.jumpMem_id         = ctrl_out.jump_mem;
   assign bus.writeBackControl_id = ctrl_out.wb_ctrl;

   assign bus.y_id         = y;
   assign bus.pc_plus_y_id = bus.pc_id + y;
   assign bus.rd_id        = bus.instr_id[RdMsb:RdLsb];

   reg_file #(
      .Regs  (REGS),
      .Width (XLEN)
   ) u_reg_file (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (bus.wb_regWrt),
      .waddr   (bus.wb_rd),
      .wdata   (bus.wb_data),
      .raddr_a (rs),
      .raddr_b (rt),
      .rdata_a (bus.xrs_id),
      .rdata_b (bus.xrt_id)
   );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected results are queued when stimulus is driven
// and popped for comparison when the combinational outputs are sampled.
module tb_id_stage;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   always #5 clock = ~clock;

   id_stage_if bus ();

   id_stage #(
      .REGS (64),
      .XLEN (32)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   localparam logic [3:0] OP_NOP = 4'b0000, OP_ST = 4'b0011, OP_ADD = 4'b0100;
   localparam logic [3:0] OP_INC = 4'b0101, OP_NEG = 4'b0110, OP_SUB = 4'b0111;
   localparam logic [3:0] OP_J = 4'b1000, OP_BRZ = 4'b1001, OP_JM = 4'b1010;
   localparam logic [3:0] OP_BRN = 4'b1011, OP_LD = 4'b1110, OP_SVPC = 4'b1111;

   // {aluOp[2:0], memRead, memWrite, aluSrc, regWrt, brZ, brN, jump, jumpMem, wbc[1:0]}
   localparam logic [12:0] C_NONE = 13'b000_0000_0000_00;
   localparam logic [12:0] C_SVPC = 13'b000_0001_0000_10;
   localparam logic [12:0] C_LD   = 13'b000_1001_0000_01;
   localparam logic [12:0] C_ST   = 13'b000_0100_0000_00;
   localparam logic [12:0] C_ADD  = 13'b001_0001_0000_00;
   localparam logic [12:0] C_INC  = 13'b001_0011_0000_00;
   localparam logic [12:0] C_NEG  = 13'b011_0001_0000_00;
   localparam logic [12:0] C_SUB  = 13'b100_0001_0000_00;
   localparam logic [12:0] C_J    = 13'b000_0000_0010_00;
   localparam logic [12:0] C_BRZ  = 13'b000_0000_1000_00;
   localparam logic [12:0] C_JM   = 13'b000_1000_0001_00;
   localparam logic [12:0] C_BRN  = 13'b000_0000_0100_00;

   // mask bits: 0 xrs, 1 xrt, 2 y and pc+y, 3 rd
   typedef struct {
      string       tag;
      logic        stall;
      logic [12:0] ctrl;
      logic [3:0]  mask;
      logic [31:0] xrs;
      logic [31:0] xrt;
      logic [31:0] y;
      logic [31:0] pcy;
      logic [5:0]  rd;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [31:0] ir(logic [3:0] op, logic [5:0] rd, logic [5:0] rs,
                                      logic [5:0] rt);
      return {op, rd, rs, rt, 10'h000};
   endfunction

   function automatic logic [31:0] ii(logic [3:0] op, logic [5:0] rd, logic [5:0] rs,
                                      logic [15:0] imm);
      return {op, rd, rs, imm};
   endfunction

   function automatic logic [31:0] val(int i);
      logic [31:0] k;
      k = 32'(i + 1);
      return 32'h9E3779B9 * k;
   endfunction

   function automatic logic [12:0] obs_ctrl();
      return {bus.aluOp_id, bus.memRead_id, bus.memWrite_id, bus.aluSrc_id, bus.regWrt_id,
              bus.branchZero_id, bus.branchNeg_id, bus.jump_id, bus.jumpMem_id,
              bus.writeBackControl_id};
   endfunction

   task automatic cmp(string tag, string what, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
      end
   endtask

   task automatic push(string tag, logic st, logic [12:0] c, logic [3:0] m, logic [31:0] xrs,
                       logic [31:0] xrt, logic [31:0] y, logic [31:0] pcy, logic [5:0] rd);
      exp_t e;
      e.tag = tag; e.stall = st; e.ctrl = c; e.mask = m;
      e.xrs = xrs; e.xrt = xrt; e.y = y; e.pcy = pcy; e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic check();
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL scoreboard observed=empty expected=entry");
         return;
      end
      e = sb.pop_front();
      cmp(e.tag, "stall", {31'b0, bus.stall}, {31'b0, e.stall});
      cmp(e.tag, "ctrl", {19'b0, obs_ctrl()}, {19'b0, e.ctrl});
      if (e.mask[0]) cmp(e.tag, "xrs", bus.xrs_id, e.xrs);
      if (e.mask[1]) cmp(e.tag, "xrt", bus.xrt_id, e.xrt);
      if (e.mask[2]) begin
         cmp(e.tag, "y", bus.y_id, e.y);
         cmp(e.tag, "pcy", bus.pc_plus_y_id, e.pcy);
      end
      if (e.mask[3]) cmp(e.tag, "rd", {26'b0, bus.rd_id}, {26'b0, e.rd});
   endtask

   task automatic set_in(logic [31:0] instr, logic [31:0] pc, logic fl, logic mre,
                         logic [5:0] rdex);
      bus.instr_id   = instr;
      bus.pc_id      = pc;
      bus.flush      = fl;
      bus.memRead_ex = mre;
      bus.rd_ex      = rdex;
   endtask

   task automatic set_wb(logic we, logic [5:0] rd, logic [31:0] d);
      bus.wb_regWrt = we;
      bus.wb_rd     = rd;
      bus.wb_data   = d;
   endtask

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
      check();
   endtask

   task automatic dec(string tag, logic [31:0] instr, logic mre, logic [5:0] rdex, logic st,
                      logic [12:0] c);
      next();
      set_in(instr, 32'h0, 1'b0, mre, rdex);
      push(tag, st, c, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      sample();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: controls and stall held low even with a load-use match present.
      set_wb(1'b0, 6'd0, 32'h0);
      set_in(ir(OP_ADD, 6'd1, 6'd3, 6'd3), 32'h0, 1'b0, 1'b1, 6'd3);
      #2;
      push("rst", 1'b0, C_NONE, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      sample();

      next();
      reset_n = 1'b1;
      set_wb(1'b1, 6'd5, 32'hDEADBEEF);
      set_in(ir(OP_ADD, 6'd1, 6'd5, 6'd2), 32'h0, 1'b0, 1'b0, 6'd0);
      push("byp0", 1'b0, C_ADD, 4'b1011, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 6'd1);
      sample();

      next();
      set_wb(1'b0, 6'd0, 32'h0);
      push("byp1", 1'b0, C_ADD, 4'b1011, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 6'd1);
      sample();

      next();
      set_in(ii(OP_INC, 6'd2, 6'd5, 16'hFFFF), 32'h100, 1'b0, 1'b0, 6'd0);
      push("inc", 1'b0, C_INC, 4'b1101, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h000000FF,
           6'd2);
      sample();

      next();
      set_in(ir(OP_SUB, 6'd3, 6'd2, 6'd7), 32'h0, 1'b0, 1'b1, 6'd7);
      push("lu_sub", 1'b1, C_NONE, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      sample();

      next();
      set_in(ir(OP_SUB, 6'd3, 6'd2, 6'd7), 32'h0, 1'b0, 1'b0, 6'd7);
      push("lu_sub_next", 1'b0, C_SUB, 4'b1000, 32'h0, 32'h0, 32'h0, 32'h0, 6'd3);
      sample();

      next();
      set_in(ir(OP_SVPC, 6'd7, 6'd7, 6'd7), 32'h40, 1'b0, 1'b1, 6'd7);
      push("svpc", 1'b0, C_SVPC, 4'b1100, 32'h0, 32'h0, 32'h00001C00, 32'h00001C40, 6'd7);
      sample();

      next();
      set_in(ir(OP_ADD, 6'd1, 6'd7, 6'd7), 32'h0, 1'b1, 1'b1, 6'd7);
      push("flush_lu", 1'b0, C_NONE, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      sample();

      next();
      set_in(ir(OP_LD, 6'd4, 6'd1, 6'd0), 32'h0, 1'b1, 1'b0, 6'd0);
      push("flush_only", 1'b0, C_NONE, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      sample();

      dec("ld", ir(OP_LD, 6'd4, 6'd1, 6'd0), 1'b0, 6'd0, 1'b0, C_LD);
      dec("ld_hz", ir(OP_LD, 6'd4, 6'd9, 6'd0), 1'b1, 6'd9, 1'b1, C_NONE);
      dec("st", ir(OP_ST, 6'd0, 6'd1, 6'd2), 1'b0, 6'd0, 1'b0, C_ST);
      dec("st_rt_hz", ir(OP_ST, 6'd0, 6'd1, 6'd9), 1'b1, 6'd9, 1'b1, C_NONE);
      dec("add_rt_hz", ir(OP_ADD, 6'd1, 6'd2, 6'd9), 1'b1, 6'd9, 1'b1, C_NONE);
      dec("inc_rt_free", ir(OP_INC, 6'd1, 6'd2, 6'd9), 1'b1, 6'd9, 1'b0, C_INC);
      dec("neg_rt_free", ir(OP_NEG, 6'd1, 6'd2, 6'd9), 1'b1, 6'd9, 1'b0, C_NEG);
      dec("neg_hz", ir(OP_NEG, 6'd1, 6'd9, 6'd0), 1'b1, 6'd9, 1'b1, C_NONE);
      dec("j", ir(OP_J, 6'd0, 6'd3, 6'd0), 1'b0, 6'd0, 1'b0, C_J);
      dec("brz", ir(OP_BRZ, 6'd0, 6'd3, 6'd0), 1'b0, 6'd0, 1'b0, C_BRZ);
      dec("jm", ir(OP_JM, 6'd0, 6'd3, 6'd0), 1'b0, 6'd0, 1'b0, C_JM);
      dec("brn", ir(OP_BRN, 6'd0, 6'd3, 6'd0), 1'b0, 6'd0, 1'b0, C_BRN);
      dec("brn_hz", ir(OP_BRN, 6'd0, 6'd9, 6'd0), 1'b1, 6'd9, 1'b1, C_NONE);
      dec("nop", ir(OP_NOP, 6'd1, 6'd9, 6'd9), 1'b1, 6'd9, 1'b0, C_NONE);
      dec("undef1", ir(4'b0001, 6'd1, 6'd9, 6'd9), 1'b1, 6'd9, 1'b0, C_NONE);
      dec("undef13", ir(4'b1101, 6'd1, 6'd9, 6'd9), 1'b1, 6'd9, 1'b0, C_NONE);
      dec("no_load", ir(OP_ADD, 6'd1, 6'd9, 6'd9), 1'b0, 6'd9, 1'b0, C_ADD);
      dec("rdex_diff", ir(OP_ADD, 6'd1, 6'd8, 6'd10), 1'b1, 6'd9, 1'b0, C_ADD);

      // Fill every entry, including 0, then read each back through both ports.
      for (int i = 0; i < 64; i++) begin
         next();
         set_in(ir(OP_NOP, 6'd0, 6'd0, 6'd0), 32'h0, 1'b0, 1'b0, 6'd0);
         set_wb(1'b1, i[5:0], val(i));
      end
      next();
      set_wb(1'b0, 6'd0, 32'h0);
      for (int i = 0; i < 64; i++) begin
         int j;
         j = 63 - i;
         set_in(ir(OP_ADD, 6'd0, i[5:0], j[5:0]), 32'h0, 1'b0, 1'b0, 6'd0);
         push("rf_read", 1'b0, C_ADD, 4'b0011, val(i), val(j), 32'h0, 32'h0, 6'd0);
         #1;
         check();
      end

      // Mid-cycle reset with a write pending: outputs clear at once, write is dropped.
      next();
      set_wb(1'b1, 6'd9, 32'h5555AAAA);
      set_in(ir(OP_ADD, 6'd1, 6'd1, 6'd2), 32'h0, 1'b0, 1'b0, 6'd0);
      #1;
      push("pre_rst", 1'b0, C_ADD, 4'b0011, val(1), val(2), 32'h0, 32'h0, 6'd0);
      check();
      #1;
      reset_n = 1'b0;
      set_in(ir(OP_ADD, 6'd1, 6'd1, 6'd2), 32'h0, 1'b0, 1'b1, 6'd1);
      #1;
      push("in_rst", 1'b0, C_NONE, 4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      check();
      next();
      push("rst_hold", 1'b0, C_NONE, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
      check();
      set_wb(1'b0, 6'd0, 32'h0);
      #2;
      reset_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         set_in(ir(OP_ADD, 6'd0, i[5:0], i[5:0]), 32'h0, 1'b0, 1'b0, 6'd0);
         push("rf_clear", 1'b0, C_ADD, 4'b0011, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0);
         #1;
         check();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
